// File: rtl/ccff_config_loader_if.sv
// Byte-stream handshake between host logic and the configuration-chain loader.
// The host (master) offers configuration bytes and receives readback bytes
// captured from the chain tail. The loader (slave) accepts the bytes and
// returns the readback.
interface ccff_config_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] tail_data;
   logic       tail_valid;

   modport master (
      output in_data, in_valid,
      input  in_ready, tail_data, tail_valid
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, tail_data, tail_valid
   );
endinterface

// File: rtl/ccff_config_loader.sv
// Configuration-chain loader for fpga_top.
// Takes bytes over a valid/ready handshake and shifts them LSB-first into the
// chain on a locally generated prog_clk. It captures the bits falling out of
// the chain tail as readback bytes, and it holds the fabric in reset until
// exactly CHAIN_LEN bits have been shifted.
module ccff_config_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int PROG_DIV  = 2,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   ccff_config_loader_if.slave bus,
   output logic                prog_clk,
   output logic                ccff_head,
   input  logic                ccff_tail,
   output logic                busy,
   output logic                done,
   output logic                fpga_rst,
   output logic [CNT_W-1:0]    bit_count
);

   localparam int               DIV_W    = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PROG_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_DONE
   } state_t;

   state_t           state;
   logic [7:0]       shreg;          // bits of the current byte still to be shifted
   logic [7:0]       acc;            // tail bits collected for the current byte
   logic [3:0]       k;              // bit index within the current byte
   logic [3:0]       bits_this_byte; // 8, or fewer for the final partial byte
   logic [DIV_W-1:0] div_cnt;        // clk cycles spent in the current prog_clk phase
   logic [CNT_W-1:0] remaining;
   logic             div_last;

   assign remaining = CNT_W'(CHAIN_LEN) - bit_count;
   assign div_last  = (div_cnt == DIV_LAST);

   // Single sequencer: every output is a register updated together with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         prog_clk       <= 1'b0;
         ccff_head      <= 1'b0;
         bus.in_ready   <= 1'b0;
         bus.tail_data  <= '0;
         bus.tail_valid <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         fpga_rst       <= 1'b1;
         bit_count      <= '0;
         // NOTE: the datapath registers are cleared as well. Only the control
         // state strictly needs a reset, but clearing these keeps readback free
         // of X after an aborted load.
         shreg          <= '0;
         acc            <= '0;
         k              <= '0;
         bits_this_byte <= '0;
         div_cnt        <= '0;
      end else begin
         // NOTE: non-blocking everywhere, so every decision in this cycle
         // sees the values the registers held before the clock edge.
         bus.tail_valid <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state        <= S_LOAD;
                  bit_count    <= '0;
                  bus.in_ready <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  fpga_rst     <= 1'b1;
               end
            end

            S_LOAD: begin
               if (bus.in_valid && bus.in_ready) begin
                  shreg          <= bus.in_data;
                  ccff_head      <= bus.in_data[0];
                  acc            <= '0;
                  k              <= '0;
                  div_cnt        <= '0;
                  bits_this_byte <= (32'(remaining) >= 32'd8) ? 4'd8 : 4'(remaining);
                  bus.in_ready   <= 1'b0;
                  state          <= S_SHIFT_LO;
               end
            end

            S_SHIFT_LO: begin
               if (div_last) begin
                  acc[k[2:0]] <= ccff_tail;
                  prog_clk    <= 1'b1;
                  div_cnt     <= '0;
                  state       <= S_SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            S_SHIFT_HI: begin
               if (div_last) begin
                  prog_clk  <= 1'b0;
                  div_cnt   <= '0;
                  bit_count <= bit_count + 1'b1;
                  k         <= k + 4'd1;
                  shreg     <= shreg >> 1;
                  if (k + 4'd1 == bits_this_byte) begin
                     bus.tail_data  <= acc;
                     bus.tail_valid <= 1'b1;
                     if (bit_count == CNT_LAST) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        fpga_rst <= 1'b0;
                     end else begin
                        state        <= S_LOAD;
                        bus.in_ready <= 1'b1;
                     end
                  end else begin
                     // Data changes together with the falling edge of prog_clk.
                     ccff_head <= shreg[1];
                     state     <= S_SHIFT_LO;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_config_loader.sv
// Self-checking bench for ccff_config_loader.
// A 20-bit chain instance covers the main scenarios. A 9-bit chain instance
// covers the partial final byte. Expected readback bytes go into queues, and a
// negedge monitor pops them whenever tail_valid pulses.
`timescale 1ns/1ps
module tb_ccff_config_loader;

   localparam int CL  = 20;
   localparam int CL9 = 9;
   localparam int PD  = 2;
   localparam int CW  = $clog2(CL + 1);
   localparam int CW9 = $clog2(CL9 + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, start9;
   logic          prog_clk, ccff_head, ccff_tail, busy, done, fpga_rst;
   logic [CW-1:0] bit_count;
   logic          prog_clk9, head9, tail9, busy9, done9, frst9;
   logic [CW9-1:0] bc9;

   ccff_config_loader_if bus ();
   ccff_config_loader_if bus9 ();

   ccff_config_loader #(.CHAIN_LEN(CL), .PROG_DIV(PD)) u_dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .prog_clk(prog_clk), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
      .busy(busy), .done(done), .fpga_rst(fpga_rst), .bit_count(bit_count)
   );

   ccff_config_loader #(.CHAIN_LEN(CL9), .PROG_DIV(PD)) u_dut9 (
      .clk(clk), .reset(reset), .start(start9), .bus(bus9),
      .prog_clk(prog_clk9), .ccff_head(head9), .ccff_tail(tail9),
      .busy(busy9), .done(done9), .fpga_rst(frst9), .bit_count(bc9)
   );

   // Behavioural chains: shift toward bit 0 on each prog_clk rise; bit 0 is the tail.
   logic [CL-1:0]  chain  = '0;
   logic [CL9-1:0] chain9 = '0;
   int             rises  = 0;
   int             rises9 = 0;

   always @(posedge prog_clk) begin
      chain <= {ccff_head, chain[CL-1:1]};
      rises <= rises + 1;
   end

   always @(posedge prog_clk9) begin
      chain9 <= {head9, chain9[CL9-1:1]};
      rises9 <= rises9 + 1;
   end

   assign ccff_tail = chain[0];
   assign tail9     = chain9[0];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   logic [7:0] exp_q[$];
   logic [7:0] exp9_q[$];
   logic       prev_pclk  = 1'b0;
   logic       prev_head  = 1'b0;
   int         hi_len     = 0;
   bit         abort_flag = 1'b0;

   // Monitor: readback scoreboard plus prog_clk/ccff_head timing on the 20-bit chain.
   always @(negedge clk) begin
      if (bus.tail_valid) begin
         if (exp_q.size() == 0) check("tail_unexpected", 32'(bus.tail_data), 32'hFFFF_FFFF);
         else                   check("tail_data", 32'(bus.tail_data), 32'(exp_q.pop_front()));
      end
      if (bus9.tail_valid) begin
         if (exp9_q.size() == 0) check("tail9_unexpected", 32'(bus9.tail_data), 32'hFFFF_FFFF);
         else                    check("tail9_data", 32'(bus9.tail_data), 32'(exp9_q.pop_front()));
      end
      if (prog_clk) begin
         check("head_stable_while_high", 32'(ccff_head), 32'(prev_head));
         hi_len <= hi_len + 1;
      end else begin
         if (prev_pclk && !abort_flag) check("prog_clk_high_cycles", hi_len, PD);
         hi_len <= 0;
      end
      prev_pclk <= prog_clk;
      prev_head <= ccff_head;
   end

   // Offer one byte once the loader is ready, after an optional idle gap.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_seen", 32'(bus.in_ready), 32'd1);
      if (gap > 0) begin
         repeat (gap) @(negedge clk);
         check("prog_clk_low_in_gap", 32'(prog_clk), 32'd0);
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Full 20-bit load: data holds byte0 in [7:0], byte1 in [15:8], byte2 in [23:16].
   task automatic do_load(input logic [23:0] data, input int gap1, input int gap2,
                          input bit poke_start, input int exp_cycles);
      int n;
      int t;
      int r0;
      r0 = rises;
      n  = 0;
      t  = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("fpga_rst_after_start", 32'(fpga_rst), 32'd1);
      check("busy_after_start", 32'(busy), 32'd1);
      check("bit_count_after_start", 32'(bit_count), 32'd0);
      fork
         begin
            send_byte(data[7:0], 0);
            send_byte(data[15:8], gap1);
            send_byte(data[23:16], gap2);
         end
         begin
            while (!done && n < 1000) begin
               @(negedge clk);
               n++;
            end
         end
         begin
            if (poke_start) begin
               while (rises - r0 < 10 && t < 1000) begin
                  @(negedge clk);
                  t++;
               end
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
            end
         end
      join
      check("load_cycles", n, exp_cycles);
      check("prog_clk_rises", rises - r0, CL);
      check("chain_contents", 32'(chain), 32'(data[CL-1:0]));
      check("done_after_load", 32'(done), 32'd1);
      check("fpga_rst_after_load", 32'(fpga_rst), 32'd0);
      check("bit_count_after_load", 32'(bit_count), CL);
      check("busy_after_load", 32'(busy), 32'd0);
   endtask

   // Two-byte load into the 9-bit chain; start and in_valid arrive together.
   task automatic do_load9(input logic [15:0] data);
      int n;
      int r0;
      r0 = rises9;
      n  = 0;
      @(negedge clk);
      bus9.in_data  = data[7:0];
      bus9.in_valid = 1'b1;
      start9        = 1'b1;
      @(negedge clk);
      start9 = 1'b0;
      fork
         begin
            for (int i = 0; i < 2; i++) begin
               int t;
               t = 0;
               bus9.in_data = data[8*i +: 8];
               while (!bus9.in_ready && t < 200) begin
                  @(negedge clk);
                  t++;
               end
               check("in_ready9_seen", 32'(bus9.in_ready), 32'd1);
               @(negedge clk);
            end
            bus9.in_valid = 1'b0;
         end
         begin
            while (!done9 && n < 1000) begin
               @(negedge clk);
               n++;
            end
         end
      join
      check("load9_cycles", n, 38);
      check("prog_clk9_rises", rises9 - r0, CL9);
      check("chain9_contents", 32'(chain9), 32'(data[CL9-1:0]));
      check("done9", 32'(done9), 32'd1);
      check("fpga_rst9", 32'(frst9), 32'd0);
      check("bit_count9", 32'(bc9), CL9);
   endtask

   initial begin
      int t;
      int r0;
      // NOTE: stimulus uses blocking assignments at the negedge, away from the DUT's sampling edge.
      reset         = 1'b1;
      start         = 1'b0;
      start9        = 1'b0;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus9.in_data  = '0;
      bus9.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset values.
      check("rst_prog_clk", 32'(prog_clk), 32'd0);
      check("rst_ccff_head", 32'(ccff_head), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_tail_data", 32'(bus.tail_data), 32'd0);
      check("rst_tail_valid", 32'(bus.tail_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_fpga_rst", 32'(fpga_rst), 32'd1);
      check("rst_bit_count", 32'(bit_count), 32'd0);

      // Basic load into an all-zero chain.
      exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      do_load(24'h0F3CA5, 0, 0, 1'b0, 83);

      // Reconfiguration from DONE: readback returns the previous load.
      exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'h0F);
      do_load(24'h332211, 0, 0, 1'b0, 83);

      // Backpressure: idle gaps of 5 and 17 cycles stretch the load by 22 cycles.
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h03);
      do_load(24'h332211, 5, 17, 1'b0, 105);

      // Start pulsed during SHIFT_HI of bit 9 is ignored.
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h03);
      do_load(24'h96C35A, 0, 0, 1'b1, 83);

      // Reset during SHIFT_HI of bit 9 of an all-ones load.
      exp_q.push_back(8'h5A);
      r0 = rises;
      t  = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      bus.in_data  = 8'hFF;
      bus.in_valid = 1'b1;
      while (rises - r0 < 10 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("abort_point_prog_clk_high", 32'(prog_clk), 32'd1);
      abort_flag = 1'b1;
      reset      = 1'b1;
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      check("abort_prog_clk", 32'(prog_clk), 32'd0);
      check("abort_bit_count", 32'(bit_count), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_fpga_rst", 32'(fpga_rst), 32'd1);
      check("abort_in_ready", 32'(bus.in_ready), 32'd0);
      repeat (5) @(negedge clk);
      check("abort_no_extra_rises", rises - r0, 10);
      abort_flag = 1'b0;

      // Chain after the abort holds ten ones above the old upper bits: 0xFFDB0.
      exp_q.push_back(8'hB0); exp_q.push_back(8'hFD); exp_q.push_back(8'h0F);
      do_load(24'h563412, 0, 0, 1'b0, 83);

      // Partial final byte on the 9-bit chain: second byte shifts a single bit.
      exp9_q.push_back(8'h00); exp9_q.push_back(8'h00);
      do_load9(16'hFFA7);
      exp9_q.push_back(8'hA7); exp9_q.push_back(8'h01);
      do_load9(16'h023C);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      check("scoreboard9_drained", exp9_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
